// File: rtl/hex_display_bank_pkg.sv
// Shared constants and types for the registered seven-segment display bank.
// Segment patterns are active-high (bit 0 = segment a); polarity is applied at the flops.
package hex_display_bank_pkg;

  // Index n holds the active-high pattern for hex digit n.
  localparam logic [15:0][6:0] SEG_PATTERN = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [6:0] SEG_OFF_HIGH = 7'h00;

  typedef struct packed {
    logic [6:0] seg;
    logic       dot;
  } digit_out_t;

  function automatic logic [6:0] seg_polarity(input logic [6:0] pat, input bit active_low);
    return active_low ? ~pat : pat;
  endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational hex nibble to active-high seven-segment pattern.
module hex_seg_decode
  import hex_display_bank_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_PATTERN[nibble];

endmodule

// File: rtl/hex_display_bank.sv
// Multi-digit seven-segment driver: load-latched value, leading-zero blanking,
// prescaled blink and fully registered segment/dot outputs.
module hex_display_bank
  import hex_display_bank_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000,
  parameter bit ACTIVE_LOW = 1'b1
)(
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_load,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic [NUM_DIGITS-1:0]   i_dots,
  input  logic                    i_lz_blank,
  input  logic [NUM_DIGITS-1:0]   i_blink_mask,
  input  logic                    i_enable,
  output logic [7*NUM_DIGITS-1:0] o_seg_data,
  output logic [NUM_DIGITS-1:0]   o_seg_dot,
  output logic                    o_blink_phase
);

  localparam int              CW      = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(BLINK_DIV - 1);
  localparam logic [6:0]      SEG_OFF = seg_polarity(SEG_OFF_HIGH, ACTIVE_LOW);

  logic [NUM_DIGITS-1:0][3:0] val_q;
  logic [NUM_DIGITS-1:0]      dot_q;
  logic [NUM_DIGITS-1:0][6:0] pat;
  logic [CW-1:0]              cnt_q;
  logic                       phase_q, phase_d, wrap;
  logic [NUM_DIGITS-1:0]      blank, off;
  logic                       seen;
  digit_out_t [NUM_DIGITS-1:0] nxt, out_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      val_q <= '0;
      dot_q <= '0;
    end else if (i_load) begin
      val_q <= i_value;
      dot_q <= i_dots;
    end
  end

  // Free-running prescaler; phase flips on each wrap regardless of the mask.
  assign wrap    = (cnt_q == CNT_MAX);
  assign phase_d = phase_q ^ wrap;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= wrap ? '0 : cnt_q + CW'(1);
      phase_q <= phase_d;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    hex_seg_decode u_dec (
      .nibble (val_q[g]),
      .seg    (pat[g])
    );
    assign o_seg_data[7*g +: 7] = out_q[g].seg;
    assign o_seg_dot[g]         = out_q[g].dot;
  end

  // Blink uses the next phase so masked digits go dark on the same edge
  // that o_blink_phase rises.
  always_comb begin
    seen  = 1'b0;
    blank = '0;
    off   = '0;
    nxt   = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (val_q[k] != 4'h0) seen = 1'b1;
      blank[k]   = i_lz_blank && !seen && (k != 0);
      off[k]     = !i_enable || (phase_d && i_blink_mask[k]);
      nxt[k].seg = seg_polarity((off[k] || blank[k]) ? SEG_OFF_HIGH : pat[k], ACTIVE_LOW);
      nxt[k].dot = !off[k] && dot_q[k];
    end
  end

  // Dots are active-high on every board variant; only segments follow ACTIVE_LOW.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        out_q[k].seg <= SEG_OFF;
        out_q[k].dot <= 1'b0;
      end
    end else begin
      out_q <= nxt;
    end
  end

  assign o_blink_phase = phase_q;

endmodule

// File: tb/tb_hex_display_bank.sv
// Directed bench for hex_display_bank with a cycle model feeding an expected-output queue.
module tb_hex_display_bank;

  localparam int ND = 6;
  localparam int BD = 4;

  logic clk = 1'b0, rst_n = 1'b0, load = 1'b0, lz = 1'b0, en = 1'b1;
  logic [4*ND-1:0] value = '0;
  logic [ND-1:0]   dots = '0, mask = '0;
  logic [7*ND-1:0] seg0, seg1;
  logic [ND-1:0]   dot0, dot1;
  logic            ph0, ph1;

  always #5 clk = ~clk;

  hex_display_bank #(.NUM_DIGITS(ND), .BLINK_DIV(BD), .ACTIVE_LOW(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_value(value), .i_dots(dots),
    .i_lz_blank(lz), .i_blink_mask(mask), .i_enable(en),
    .o_seg_data(seg0), .o_seg_dot(dot0), .o_blink_phase(ph0)
  );

  hex_display_bank #(.NUM_DIGITS(ND), .BLINK_DIV(BD), .ACTIVE_LOW(1'b0)) dut_hi (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_value(value), .i_dots(dots),
    .i_lz_blank(lz), .i_blink_mask(mask), .i_enable(en),
    .o_seg_data(seg1), .o_seg_dot(dot1), .o_blink_phase(ph1)
  );

  int ntests = 0, nfail = 0;

  logic [4*ND-1:0] m_val = '0;
  logic [ND-1:0]   m_dots = '0;
  int              m_cnt = 0;
  logic            m_ph = 1'b0;

  typedef struct {
    logic [7*ND-1:0] seg;
    logic [ND-1:0]   dot;
    logic            ph;
  } exp_t;
  exp_t sb[$];

  function automatic logic [6:0] hexpat(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Predict the outputs after the coming edge, advance the model, then compare.
  task automatic step(input string tag);
    exp_t e;
    logic ph_n, seen, off, blank;
    logic [3:0] nib;
    ph_n = m_ph ^ (m_cnt == BD - 1);
    seen = 1'b0;
    for (int k = ND - 1; k >= 0; k--) begin
      nib = m_val[4*k +: 4];
      if (nib != 4'h0) seen = 1'b1;
      blank = lz && !seen && (k != 0);
      off   = !en || (ph_n && mask[k]);
      e.seg[7*k +: 7] = (off || blank) ? 7'h7F : ~hexpat(nib);
      e.dot[k]        = off ? 1'b0 : m_dots[k];
    end
    e.ph = ph_n;
    sb.push_back(e);
    if (load) begin
      m_val  = value;
      m_dots = dots;
    end
    m_cnt = (m_cnt == BD - 1) ? 0 : m_cnt + 1;
    m_ph  = ph_n;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, "_seg"}, 64'(seg0), 64'(e.seg));
    chk({tag, "_dot"}, 64'(dot0), 64'(e.dot));
    chk({tag, "_phase"}, 64'(ph0), 64'(e.ph));
  endtask

  task automatic model_reset();
    m_val = '0; m_dots = '0; m_cnt = 0; m_ph = 1'b0;
  endtask

  initial begin
    int toggles;
    logic last_ph;

    // Reset held across several edges
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg", 64'(seg0), 64'({42{1'b1}}));
    chk("rst_dot", 64'(dot0), 64'd0);
    chk("rst_phase", 64'(ph0), 64'd0);
    chk("rst_seg_hi", 64'(seg1), 64'd0);
    rst_n = 1'b1;
    model_reset();
    step("idle0");
    step("idle1");

    // Load latency: edge k captures, edge k+1 drives pins
    value = 24'h0123AF; dots = 6'b000001; load = 1'b1;
    step("load_k");
    load = 1'b0;
    step("load_k1");
    chk("load_d0", 64'(seg0[6:0]), 64'h0E);
    chk("load_d1", 64'(seg0[13:7]), 64'h08);
    chk("load_d5", 64'(seg0[41:35]), 64'h40);
    chk("load_dot0", 64'(dot0), 64'h01);

    // Leading-zero suppression
    lz = 1'b1; value = 24'h000450; dots = 6'b000000; load = 1'b1;
    step("lz_load");
    load = 1'b0;
    step("lz_show");
    chk("lz_d5_3", 64'(seg0[41:21]), 64'({21{1'b1}}));
    chk("lz_d2", 64'(seg0[20:14]), 64'h19);
    chk("lz_d1", 64'(seg0[13:7]), 64'h12);
    chk("lz_d0", 64'(seg0[6:0]), 64'h40);
    value = 24'h000000; load = 1'b1;
    step("lz0_load");
    load = 1'b0;
    step("lz0_show");
    chk("lz0_upper", 64'(seg0[41:7]), 64'({35{1'b1}}));
    chk("lz0_d0", 64'(seg0[6:0]), 64'h40);

    // Blink on digits 0-1
    lz = 1'b0; value = 24'h0123AF; dots = 6'b000011; load = 1'b1;
    step("bl_load");
    load = 1'b0;
    mask = 6'b000011;
    toggles = 0;
    last_ph = ph0;
    for (int i = 0; i < 16; i++) begin
      step("blink");
      if (ph0 !== last_ph) toggles++;
      last_ph = ph0;
      if (ph0) begin
        chk("blink_off_d01", 64'(seg0[13:0]), 64'h3FFF);
        chk("blink_off_dot", 64'(dot0[1:0]), 64'd0);
      end else begin
        chk("blink_on_d0", 64'(seg0[6:0]), 64'h0E);
      end
      chk("blink_steady_d2", 64'(seg0[20:14]), 64'h30);
    end
    chk("blink_toggles", 64'(toggles), 64'd4);

    // Enable low overrides everything; phase keeps running underneath
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step("dis");
      chk("dis_seg", 64'(seg0), 64'({42{1'b1}}));
      chk("dis_dot", 64'(dot0), 64'd0);
    end
    en = 1'b1; mask = '0;
    step("reen");
    chk("reen_d0", 64'(seg0[6:0]), 64'h0E);
    step("reen2");

    // Asynchronous reset away from any edge
    #2 rst_n = 1'b0;
    #1;
    chk("arst_seg", 64'(seg0), 64'({42{1'b1}}));
    chk("arst_dot", 64'(dot0), 64'd0);
    chk("arst_phase", 64'(ph0), 64'd0);
    chk("arst_seg_hi", 64'(seg1), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    step("post_rst");

    // Active-high polarity instance
    value = 24'h000008; dots = '0; load = 1'b1;
    step("pol_load");
    load = 1'b0;
    step("pol_show");
    chk("pol_hi_d0", 64'(seg1[6:0]), 64'h7F);
    chk("pol_hi_d1", 64'(seg1[13:7]), 64'h3F);
    chk("pol_hi_dot", 64'(dot1), 64'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/hex_display_bank.md
Name: hex_display_bank

Overview:
- Registered, parametrised multi-digit seven-segment driver for the board's static HEX displays.
- Replaces per-digit combinational decoders with one block that:
  - latches a packed hex value on a load strobe;
  - suppresses leading zeros;
  - blinks selected digits from a built-in prescaler;
  - drives all segment and dot outputs from flops.
- Sits between counter/application logic and the HEX0..HEXn pins.

Parameters:
- NUM_DIGITS, 6, number of digits driven (1..8).
- BLINK_DIV, 25000000, clock cycles per blink half-period (>= 2); default gives 1 Hz at 50 MHz.
- ACTIVE_LOW, 1, 1 = segment lit by driving 0 (board default); 0 = lit by driving 1.

Ports:
- i_clk  input  1  system clock; all flops on rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_load  input  1  when high, capture i_value and i_dots on this edge.
- i_value  input  4*NUM_DIGITS  packed hex digits; digit 0 (least significant) in [3:0].
- i_dots  input  NUM_DIGITS  decimal-point request per digit, captured with i_value.
- i_lz_blank  input  1  leading-zero suppression enable; level, sampled every cycle.
- i_blink_mask  input  NUM_DIGITS  digits to blink; level, sampled every cycle.
- i_enable  input  1  0 = blank entire display; level.
- o_seg_data  output  7*NUM_DIGITS  segments g..a per digit; digit k in [7k+6:7k], bit 0 = segment a.
- o_seg_dot  output  NUM_DIGITS  decimal point per digit.
- o_blink_phase  output  1  current blink phase (1 = off phase), for sync with other indicators.

Behaviour:
- Reset (async, i_rst_n low):
  - value register = 0; dot register = 0; prescaler = 0; blink phase = 0.
  - o_seg_data all segments off: all ones if ACTIVE_LOW, else all zeros.
  - o_seg_dot off; o_blink_phase = 0.
  - Release is used synchronously; the first output update is on the first edge after deassertion.
- Load:
  - i_load high at edge k: value/dot registers hold the new data after edge k.
  - o_seg_data/o_seg_dot reflect it after edge k+1 (2-cycle latency from strobe to pins).
  - Without i_load the registers hold.
  - Back-to-back loads each take effect; the last one wins.
- Decode:
  - Standard hex patterns, active-high form before polarity: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71.
  - Inverted when ACTIVE_LOW=1.
- Leading-zero suppression (i_lz_blank=1):
  - Scan from the most significant digit downward.
  - Each digit equal to 0 is blanked until the first non-zero digit.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - Dots of blanked digits still follow the dot register.
- Blink:
  - Prescaler counts 0..BLINK_DIV-1 continuously, independent of the mask.
  - On the wrap from BLINK_DIV-1 to 0, the blink phase toggles.
  - While phase = 1, each digit with its i_blink_mask bit set has segments and dot forced off.
  - Mask changes take effect on the next output update (1 cycle).
- Priority per digit, highest first:
  1. i_enable=0 → off.
  2. Blink off phase → off.
  3. LZ blank → segments off.
  4. Decoded pattern.
- Simultaneous events:
  - Load coincident with a prescaler wrap: both apply; new data is shown with the new phase after edge k+1.
  - Reset mid-blink restarts the phase at 0 (on).
- Width rules:
  - Prescaler width = clog2(BLINK_DIV).
  - No combinational path from any input to any output.

Decomposition:
- Shared package/include holds:
  - the 16-entry SEG_PATTERN constant table (active-high);
  - SEG_OFF_HIGH = 7'h00;
  - a polarity helper.
- One sub-module: hex_seg_decode (4-bit nibble in, 7-bit active-high pattern out, purely combinational), instantiated NUM_DIGITS times via generate.
- Leading-zero scan, blink prescaler and output registers stay in the top.

Test Plan:
- Reset check (defaults, BLINK_DIV=4 for sim):
  - Stimulus: hold i_rst_n low, toggle the clock.
  - Response: o_seg_data = all ones (42 bits), o_seg_dot = 0 (all off), o_blink_phase = 0.
  - Stimulus: assert reset asynchronously mid-cycle.
  - Response: outputs go off immediately.
- Load latency:
  - Stimulus: i_value=24'h0123AF, i_dots=6'b000001, i_load pulse at edge k.
  - Response: after edge k+1, digit0 = ~7'h71, digit1 = ~7'h77, digit5 = ~7'h3F, dot0 lit; before edge k+1, outputs unchanged.
- Leading-zero suppression:
  - Stimulus: i_lz_blank=1, load 24'h000450.
  - Response: digits 5..3 off, digit2 = ~7'h66, digit1 = ~7'h6D, digit0 = ~7'h3F.
  - Stimulus: load 24'h000000.
  - Response: only digit0 shows ~7'h3F.
- Blink timing:
  - Stimulus: i_blink_mask=6'b000011, BLINK_DIV=4.
  - Response: o_blink_phase toggles every 4 cycles; digits 0–1 are off whenever phase = 1; other digits are steady.
- Enable priority:
  - Stimulus: i_enable=0 with loaded data and blink active.
  - Response: all digits and dots off.
  - Stimulus: re-enable.
  - Response: display restores within 1 cycle; the blink phase was not disturbed.
- Polarity:
  - Stimulus: ACTIVE_LOW=0, load 24'h000008.
  - Response: digit0 = 7'h7F; reset value = all zeros.
